// File: rtl/ecc32_scrub_ctrl.sv
// ecc32_scrub_ctrl: shares one SECDED decoder/encoder between host reads and a background RAM scrubber.
// Code layout: Hamming positions 1..38, check bits at powers of two, check bit 6 is overall parity.
module ecc32_scrub_ctrl #(
  parameter int ADR_WIDTH = 8,
  parameter int SCRUB_GAP = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 scrub_en,
  input  logic                 host_req,
  input  logic [ADR_WIDTH-1:0] host_adr,
  output logic                 host_ack,
  output logic [31:0]          host_data,
  output logic [1:0]           host_err,
  output logic [ADR_WIDTH-1:0] ram_adr,
  output logic                 ram_rd,
  input  logic [31:0]          ram_rdata,
  input  logic [6:0]           ram_rparity,
  output logic                 ram_wr,
  output logic [31:0]          ram_wdata,
  output logic [6:0]           ram_wparity,
  output logic [15:0]          sbe_cnt,
  output logic [15:0]          dbe_cnt,
  input  logic                 cnt_clear,
  output logic [ADR_WIDTH-1:0] last_dbe_adr,
  output logic                 pass_done
);
  localparam int GW = $clog2(SCRUB_GAP + 2);
  typedef enum logic [2:0] {IDLE, H_RD, H_DEC, S_RD, S_DEC, WB, GAP} state_t;
  function automatic logic [6:0] ecc32_encode(input logic [31:0] d);
    logic [5:0] s;
    logic [4:0] k;
    s = '0;
    k = '0;
    for (int i = 1; i < 39; i++)
      if ((i & (i - 1)) != 0) begin
        if (d[k]) s ^= 6'(i);
        k++;
      end
    return {^d ^ ^s, s};
  endfunction
  // returns {code, corrected data}; codes 00 none, 01 single, 10 double, 11 check-bit/uncorrectable
  function automatic logic [33:0] ecc32_decode(input logic ecc_en, input logic [31:0] d,
                                               input logic [6:0] p);
    logic [6:0]  e;
    logic [5:0]  s;
    logic [4:0]  k;
    logic [31:0] c;
    logic        odd;
    logic        hit;
    e   = ecc32_encode(d);
    s   = p[5:0] ^ e[5:0];
    odd = ^{d, p};
    c   = d;
    hit = 1'b0;
    k   = '0;
    for (int i = 1; i < 39; i++)
      if ((i & (i - 1)) != 0) begin
        if (odd && s == 6'(i)) begin
          c[k] = ~d[k];
          hit  = 1'b1;
        end
        k++;
      end
    return ecc_en ? {odd ? (hit ? 2'b01 : 2'b11) : (s != '0 ? 2'b10 : 2'b00), c} : {2'b00, d};
  endfunction
  state_t               r_state, w_next;
  logic [ADR_WIDTH-1:0] r_ptr;
  logic [GW-1:0]        r_gap;
  logic                 r_host_wb;
  logic [33:0]          w_dec;
  logic [1:0]           w_err;
  logic [31:0]          w_cor;
  logic [6:0]           w_par;
  logic                 w_hreq, w_dec_st, w_dbe, w_gap_in, w_gap_done;
  assign w_dec      = ecc32_decode(1'b1, ram_rdata, ram_rparity);
  assign w_err      = w_dec[33:32];
  assign w_cor      = w_dec[31:0];
  assign w_par      = ecc32_encode(w_cor);
  // a request still high in the ack cycle is the one just served
  assign w_hreq     = host_req & ~host_ack;
  assign w_dec_st   = (r_state == H_DEC) || (r_state == S_DEC);
  assign w_dbe      = w_dec_st && (w_err == 2'b10);
  assign w_gap_done = r_gap >= GW'(SCRUB_GAP);
  assign w_gap_in   = (w_next == GAP) && (r_state != GAP);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_hreq ? H_RD : (scrub_en ? S_RD : IDLE);
      H_RD:    w_next = H_DEC;
      H_DEC:   w_next = w_err[0] ? WB : IDLE;
      S_RD:    w_next = S_DEC;
      S_DEC:   w_next = w_err[0] ? WB : GAP;
      WB:      w_next = r_host_wb ? IDLE : GAP;
      GAP:     w_next = w_hreq ? H_RD : ((!scrub_en || w_gap_done) ? IDLE : GAP);
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      host_ack     <= 1'b0;
      host_data    <= '0;
      host_err     <= '0;
      ram_adr      <= '0;
      ram_rd       <= 1'b0;
      ram_wr       <= 1'b0;
      ram_wdata    <= '0;
      ram_wparity  <= '0;
      sbe_cnt      <= '0;
      dbe_cnt      <= '0;
      last_dbe_adr <= '0;
      pass_done    <= 1'b0;
      r_ptr        <= '0;
      r_gap        <= '0;
      r_host_wb    <= 1'b0;
    end else begin
      ram_rd    <= (w_next == H_RD) || (w_next == S_RD);
      ram_wr    <= w_next == WB;
      host_ack  <= r_state == H_DEC;
      pass_done <= w_gap_in && (&r_ptr);
      r_gap     <= (r_state == GAP) ? r_gap + 1'b1 : GW'(1);
      sbe_cnt   <= cnt_clear ? '0 : sbe_cnt + 16'((r_state == WB) && !(&sbe_cnt));
      dbe_cnt   <= cnt_clear ? '0 : dbe_cnt + 16'(w_dbe && !(&dbe_cnt));
      if (w_next == H_RD) ram_adr <= host_adr;
      else if (w_next == S_RD) ram_adr <= r_ptr;
      if (w_gap_in) r_ptr <= r_ptr + 1'b1;
      if (w_dbe) last_dbe_adr <= ram_adr;
      if (r_state == H_DEC) begin
        host_data <= w_cor;
        host_err  <= w_err;
      end
      if (w_dec_st) begin
        ram_wdata   <= w_cor;
        ram_wparity <= w_par;
        r_host_wb   <= r_state == H_DEC;
      end
    end
endmodule

// File: tb/tb_ecc32_scrub_ctrl.sv
// tb_ecc32_scrub_ctrl: directed host-read vector table plus hand-written scrub sequences
// against a behavioural RAM with an independent check-bit model.
module tb_ecc32_scrub_ctrl;
  logic        clock, reset_n, scrub_en, host_req, cnt_clear;
  logic [3:0]  host_adr, ram_adr, last_dbe_adr;
  logic        host_ack, ram_rd, ram_wr, pass_done;
  logic [31:0] host_data, ram_rdata, ram_wdata;
  logic [1:0]  host_err;
  logic [6:0]  ram_rparity, ram_wparity;
  logic [15:0] sbe_cnt, dbe_cnt;

  ecc32_scrub_ctrl #(.ADR_WIDTH(4), .SCRUB_GAP(3)) dut (
    .clock(clock), .reset_n(reset_n), .scrub_en(scrub_en), .host_req(host_req),
    .host_adr(host_adr), .host_ack(host_ack), .host_data(host_data), .host_err(host_err),
    .ram_adr(ram_adr), .ram_rd(ram_rd), .ram_rdata(ram_rdata), .ram_rparity(ram_rparity),
    .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_wparity(ram_wparity), .sbe_cnt(sbe_cnt),
    .dbe_cnt(dbe_cnt), .cnt_clear(cnt_clear), .last_dbe_adr(last_dbe_adr), .pass_done(pass_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // data-bit positions of the 38-bit Hamming word (powers of two hold check bits)
  int pos [32] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21,
                   22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 33, 34, 35, 36, 37, 38};
  function automatic logic [6:0] enc(input logic [31:0] dv);
    logic [6:0] p;
    p = '0;
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 32; j++)
        if (pos[j][k]) p[k] = p[k] ^ dv[j];
    p[6] = ^{dv, p[5:0]};
    return p;
  endfunction

  logic [31:0] mem_d [16];
  logic [6:0]  mem_p [16];
  logic [31:0] good  [16];
  int          reads = 0, writes = 0, passes = 0;
  logic [3:0]  wr_adr;
  logic        pk = 1'b0;
  logic [3:0]  pk_a;
  logic [31:0] pk_d;
  logic [6:0]  pk_p;

  always @(posedge clock) begin
    if (ram_rd) begin
      ram_rdata   <= mem_d[ram_adr];
      ram_rparity <= mem_p[ram_adr];
      reads       <= reads + 1;
    end
    if (ram_wr) begin
      mem_d[ram_adr] <= ram_wdata;
      mem_p[ram_adr] <= ram_wparity;
      writes         <= writes + 1;
      wr_adr         <= ram_adr;
    end
    if (pk) begin
      mem_d[pk_a] <= pk_d;
      mem_p[pk_a] <= pk_p;
    end
    if (pass_done) passes <= passes + 1;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic poke(input logic [3:0] a, input logic [31:0] dv, input logic [6:0] pv);
    pk = 1'b1; pk_a = a; pk_d = dv; pk_p = pv;
    @(negedge clock);
    pk = 1'b0;
  endtask

  task automatic fill_clean();
    for (int a = 0; a < 16; a++) poke(4'(a), good[a], enc(good[a]));
  endtask

  task automatic clr();
    cnt_clear = 1'b1;
    @(negedge clock);
    cnt_clear = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    check(nm, {host_ack, host_data, host_err, ram_adr, ram_rd, ram_wr, ram_wdata, ram_wparity,
               sbe_cnt, dbe_cnt, last_dbe_adr, pass_done}, '0);
  endtask

  // raise the request now; lat counts negedges until host_ack is seen
  task automatic host_read(input logic [3:0] a, output logic [31:0] dv, output logic [1:0] ev,
                           output int lat);
    host_adr = a;
    host_req = 1'b1;
    @(negedge clock);
    lat = 1;
    while (!host_ack && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check("ack_seen", host_ack, 1'b1);
    dv = host_data;
    ev = host_err;
    host_req = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  adr;
    logic [31:0] data;
    logic [31:0] dflip;
    logic [6:0]  pflip;
    logic [1:0]  err;
    logic [31:0] hdata;
    logic        wb;
  } vec_t;
  vec_t vt [7];

  logic [31:0] d;
  logic [1:0]  e;
  int          lat, w0, r0, p0, e_sbe, e_dbe;
  logic [3:0]  a0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'd1, 32'hDEADBEEF, 32'h0,        7'h00, 2'b00, 32'hDEADBEEF, 1'b0};
    vt[1] = '{4'd2, 32'hA5A50F0F, 32'h00000080, 7'h00, 2'b01, 32'hA5A50F0F, 1'b1};
    vt[2] = '{4'd9, 32'h12345678, 32'h0,        7'h04, 2'b11, 32'h12345678, 1'b1};
    vt[3] = '{4'd3, 32'h00000000, 32'h00000003, 7'h00, 2'b10, 32'h00000003, 1'b0};
    vt[4] = '{4'd4, 32'hFFFFFFFF, 32'h80000000, 7'h00, 2'b01, 32'hFFFFFFFF, 1'b1};
    vt[5] = '{4'd6, 32'h0F0F0F0F, 32'h0,        7'h40, 2'b11, 32'h0F0F0F0F, 1'b1};
    vt[6] = '{4'd7, 32'hCAFEF00D, 32'h00000001, 7'h01, 2'b10, 32'hCAFEF00C, 1'b0};
    for (int i = 0; i < 16; i++) good[i] = 32'h9E3779B9 * 32'(i + 1);
    reset_n = 1'b0; scrub_en = 1'b0; host_req = 1'b0; cnt_clear = 1'b0; host_adr = '0;
    tick(3);
    check_zero("reset_outputs");
    reset_n = 1'b1;
    fill_clean();

    // host-path vectors, scrubber off
    e_sbe = 0;
    e_dbe = 0;
    for (int i = 0; i < 7; i++) begin
      poke(vt[i].adr, vt[i].data ^ vt[i].dflip, enc(vt[i].data) ^ vt[i].pflip);
      w0 = writes;
      host_read(vt[i].adr, d, e, lat);
      check($sformatf("vec%0d_lat", i), lat, 3);
      check($sformatf("vec%0d_err", i), e, vt[i].err);
      check($sformatf("vec%0d_data", i), d, vt[i].hdata);
      tick(3);
      e_sbe += int'(vt[i].wb);
      e_dbe += int'(vt[i].err == 2'b10);
      check($sformatf("vec%0d_writes", i), writes - w0, vt[i].wb);
      if (vt[i].wb) check($sformatf("vec%0d_fixed", i), {mem_d[vt[i].adr], mem_p[vt[i].adr]},
                          {vt[i].data, enc(vt[i].data)});
      check($sformatf("vec%0d_sbe", i), sbe_cnt, e_sbe);
      check($sformatf("vec%0d_dbe", i), dbe_cnt, e_dbe);
      if (vt[i].err == 2'b10) check($sformatf("vec%0d_dbe_adr", i), last_dbe_adr, vt[i].adr);
    end

    // clean RAM: two full passes, no writes, counters stay 0
    fill_clean();
    clr();
    check("clear_sbe", sbe_cnt, 0);
    check("clear_dbe", dbe_cnt, 0);
    r0 = reads; w0 = writes; p0 = passes;
    scrub_en = 1'b1;
    for (int i = 0; i < 400 && passes != p0 + 1; i++) @(negedge clock);
    check("clean_pass1", passes - p0, 1);
    check("clean_reads1", reads - r0, 16);
    for (int i = 0; i < 400 && passes != p0 + 2; i++) @(negedge clock);
    check("clean_pass2", passes - p0, 2);
    check("clean_reads2", reads - r0, 32);
    check("clean_writes", writes - w0, 0);
    check("clean_cnts", {sbe_cnt, dbe_cnt}, 0);
    scrub_en = 1'b0;
    tick(10);

    // word 5 data bit 7 flipped: one write-back, none on the next pass
    poke(4'd5, good[5] ^ 32'h80, enc(good[5]));
    clr();
    w0 = writes;
    scrub_en = 1'b1;
    for (int i = 0; i < 400 && writes == w0; i++) @(negedge clock);
    check("sbe5_writes", writes - w0, 1);
    check("sbe5_adr", wr_adr, 5);
    check("sbe5_fixed", {mem_d[5], mem_p[5]}, {good[5], enc(good[5])});
    tick(2);
    check("sbe5_cnt", sbe_cnt, 1);
    p0 = passes;
    for (int i = 0; i < 400 && passes != p0 + 2; i++) @(negedge clock);
    check("sbe5_pass2", passes - p0, 2);
    check("sbe5_no_rewrite", writes - w0, 1);
    scrub_en = 1'b0;
    tick(10);

    // word 3 double error: counted, not written; host read of it counts again
    poke(4'd3, good[3] ^ 32'h3, enc(good[3]));
    clr();
    w0 = writes;
    scrub_en = 1'b1;
    for (int i = 0; i < 400 && dbe_cnt == 0; i++) @(negedge clock);
    scrub_en = 1'b0;
    check("dbe3_cnt", dbe_cnt, 1);
    check("dbe3_adr", last_dbe_adr, 3);
    tick(10);
    check("dbe3_no_write", writes - w0, 0);
    host_read(4'd3, d, e, lat);
    check("dbe3_host_err", e, 2'b10);
    tick(1);
    check("dbe3_host_cnt", dbe_cnt, 2);
    check("dbe3_host_adr", last_dbe_adr, 3);
    poke(4'd3, good[3], enc(good[3]));

    // host request raised during a scrub write-back waits for it
    poke(4'd8, good[8] ^ 32'h0010_0000, enc(good[8]));
    w0 = writes;
    scrub_en = 1'b1;
    for (int i = 0; i < 400 && !ram_wr; i++) @(negedge clock);
    check("wbhost_wr_seen", ram_wr, 1'b1);
    check("wbhost_wr_adr", ram_adr, 8);
    host_read(4'd1, d, e, lat);
    check("wbhost_lat", lat, 4);
    check("wbhost_data", d, good[1]);
    check("wbhost_err", e, 2'b00);
    check("wbhost_writes", writes - w0, 1);
    check("wbhost_fixed", {mem_d[8], mem_p[8]}, {good[8], enc(good[8])});
    scrub_en = 1'b0;
    tick(10);

    // host request in the first GAP clock aborts the gap; pointer already advanced
    scrub_en = 1'b1;
    for (int i = 0; i < 50 && !ram_rd; i++) @(negedge clock);
    a0 = ram_adr;
    tick(2);
    host_read(4'd2, d, e, lat);
    check("gap_abort_lat", lat, 3);
    check("gap_abort_data", d, good[2]);
    for (int i = 0; i < 50 && !ram_rd; i++) @(negedge clock);
    check("gap_next_adr", ram_adr, a0 + 4'd1);
    scrub_en = 1'b0;
    tick(10);

    // cnt_clear in the same clock as a write-back increment leaves 0
    poke(4'd10, good[10], enc(good[10]) ^ 7'h10);
    host_read(4'd10, d, e, lat);
    check("clr_err", e, 2'b11);
    check("clr_wr_now", {ram_wr, ram_rd}, 2'b10);
    cnt_clear = 1'b1;
    @(negedge clock);
    cnt_clear = 1'b0;
    check("clr_wins", sbe_cnt, 0);
    check("clr_fixed", mem_p[10], enc(good[10]));
    tick(3);

    // reset during a write-back drops ram_wr at once
    poke(4'd11, good[11] ^ 32'h8000_0000, enc(good[11]));
    w0 = writes;
    host_read(4'd11, d, e, lat);
    check("rst_wr_before", ram_wr, 1'b1);
    #1 reset_n = 1'b0;
    #1 check("rst_wr_dropped", ram_wr, 1'b0);
    check_zero("rst_mid_outputs");
    @(negedge clock);
    check("rst_no_write", writes - w0, 0);
    reset_n = 1'b1;
    tick(2);
    host_read(4'd11, d, e, lat);
    check("post_rst_lat", lat, 3);
    check("post_rst_err", e, 2'b01);
    check("post_rst_data", d, good[11]);
    tick(2);
    check("post_rst_sbe", sbe_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
